// File: rtl/tx_pkg.sv
// Shared command encodings, FSM states and default widths for the transmit pulse generator.
package tx_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_BUFFER = 2'b01,
        CMD_FIRE   = 2'b10,
        CMD_RESET  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int TX_N_CH    = 8;
    localparam int TX_PD_W    = 16;
    localparam int TX_CT_W    = 9;
    localparam int TX_PER_W   = 17;
    localparam int TX_BURST_W = 8;
    localparam int TX_MAX_ON  = 512;

endpackage

// File: rtl/tx_channel_slot.sv
// One transducer channel: shadow/active timing, pulse window compare and on-time safety limiter.
module tx_channel_slot
    import tx_pkg::*;
#(
    parameter int PD_W   = TX_PD_W,
    parameter int CT_W   = TX_CT_W,
    parameter int PER_W  = TX_PER_W,
    parameter int MAX_ON = TX_MAX_ON
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [PD_W-1:0]  wr_pd,
    input  logic [CT_W-1:0]  wr_ct,
    input  logic             shadow_clr,
    input  logic             latch,
    input  logic             run,
    input  logic             wrap,
    input  logic             clear,
    input  logic [PER_W-1:0] cnt,
    output logic             tx_out,
    output logic             err_flag
);

    localparam int ON_W = $clog2(MAX_ON + 1);

    logic [PD_W-1:0]  sh_pd_q, sh_pd_d, pd_q, pd_d;
    logic [CT_W-1:0]  sh_ct_q, sh_ct_d, ct_q, ct_d;
    logic [ON_W-1:0]  on_q, on_d;
    logic             tx_q, tx_d, err_q, err_d, mute_q, mute_d;
    logic [PER_W-1:0] win_lo, win_hi;
    logic             in_win, trip;

    always_comb begin
        sh_pd_d = sh_pd_q;
        sh_ct_d = sh_ct_q;
        if (shadow_clr) begin
            sh_pd_d = '0;
            sh_ct_d = '0;
        end else if (wr_en) begin
            sh_pd_d = wr_pd;
            sh_ct_d = wr_ct;
        end

        pd_d = latch ? sh_pd_q : pd_q;
        ct_d = latch ? sh_ct_q : ct_q;

        // PER_W is wider than both operands, so pd+ct never wraps.
        win_lo = PER_W'(pd_q);
        win_hi = win_lo + PER_W'(ct_q);
        in_win = (cnt >= win_lo) && (cnt < win_hi);

        trip   = tx_q && (on_q == ON_W'(MAX_ON));
        mute_d = latch ? 1'b0 : (mute_q | trip);
        tx_d   = run && !wrap && in_win && !mute_q && !trip;
        on_d   = tx_d ? on_q + ON_W'(1) : '0;
        err_d  = clear ? 1'b0 : (err_q | trip);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_pd_q <= '0;
            sh_ct_q <= '0;
            pd_q    <= '0;
            ct_q    <= '0;
            on_q    <= '0;
            tx_q    <= 1'b0;
            err_q   <= 1'b0;
            mute_q  <= 1'b0;
        end else begin
            sh_pd_q <= sh_pd_d;
            sh_ct_q <= sh_ct_d;
            pd_q    <= pd_d;
            ct_q    <= ct_d;
            on_q    <= on_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
            mute_q  <= mute_d;
        end
    end

    assign tx_out   = tx_q;
    assign err_flag = err_q;

endmodule

// File: rtl/tx_channel_array.sv
// Multi-channel burst pulse generator: command decode, burst FSM and shared period/pulse counters.
module tx_channel_array
    import tx_pkg::*;
#(
    parameter int N_CH    = TX_N_CH,
    parameter int PD_W    = TX_PD_W,
    parameter int CT_W    = TX_CT_W,
    parameter int PER_W   = TX_PER_W,
    parameter int BURST_W = TX_BURST_W,
    parameter int MAX_ON  = TX_MAX_ON,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         cmd,
    input  logic               cfg_wr,
    input  logic [CH_W-1:0]    cfg_chan,
    input  logic [PD_W-1:0]    cfg_pd,
    input  logic [CT_W-1:0]    cfg_ct,
    input  logic [BURST_W-1:0] burst_count,
    input  logic [PER_W-1:0]   burst_period,
    output logic [N_CH-1:0]    tx_out,
    output logic               is_active,
    output logic               done,
    output logic               cfg_err,
    output logic [N_CH-1:0]    err_flags
);

    cmd_e               cmd_s;
    state_e             state_q, state_d;
    logic [PER_W-1:0]   cnt_q, cnt_d, period_q, period_d;
    logic [BURST_W-1:0] pulse_q, pulse_d, burst_q, burst_d;
    logic               is_active_q, is_active_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic               latch, run, wrap, err_clr, shadow_clr, chan_ok, wr_ok;

    assign cmd_s      = cmd_e'(cmd);
    assign chan_ok    = 32'(cfg_chan) < N_CH;
    assign err_clr    = (cmd_s == CMD_IDLE) || (cmd_s == CMD_RESET);
    assign shadow_clr = (cmd_s == CMD_RESET);
    assign wr_ok      = cfg_wr && (cmd_s == CMD_BUFFER) && (state_q != S_RUN) && chan_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = pulse_q;
        burst_d     = burst_q;
        period_d    = period_q;
        is_active_d = is_active_q;
        done_d      = 1'b0;
        latch       = 1'b0;
        run         = 1'b0;
        wrap        = 1'b0;

        cfg_err_d = cfg_err_q;
        if (err_clr)
            cfg_err_d = 1'b0;
        else if (cfg_wr && !wr_ok)
            cfg_err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_s == CMD_FIRE) begin
                    latch       = 1'b1;
                    cnt_d       = '0;
                    pulse_d     = '0;
                    burst_d     = (burst_count == '0) ? BURST_W'(1) : burst_count;
                    period_d    = (burst_period == '0) ? PER_W'(1) : burst_period;
                    state_d     = S_RUN;
                    is_active_d = 1'b1;
                end
            end
            S_RUN: begin
                if (cmd_s != CMD_FIRE) begin
                    state_d     = S_IDLE;
                    is_active_d = 1'b0;
                end else begin
                    run = 1'b1;
                    if (cnt_q == period_q - PER_W'(1)) begin
                        wrap    = 1'b1;
                        cnt_d   = '0;
                        pulse_d = pulse_q + BURST_W'(1);
                        if (pulse_q == burst_q - BURST_W'(1)) begin
                            state_d     = S_DONE;
                            done_d      = 1'b1;
                            is_active_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + PER_W'(1);
                    end
                end
            end
            // Hold here until FIRE is released so a held FIRE cannot retrigger.
            S_DONE: begin
                if (cmd_s != CMD_FIRE)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pulse_q     <= '0;
            burst_q     <= '0;
            period_q    <= '0;
            is_active_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            burst_q     <= burst_d;
            period_q    <= period_d;
            is_active_q <= is_active_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tx_channel_slot #(
            .PD_W  (PD_W),
            .CT_W  (CT_W),
            .PER_W (PER_W),
            .MAX_ON(MAX_ON)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_en     (wr_ok && (32'(cfg_chan) == i)),
            .wr_pd     (cfg_pd),
            .wr_ct     (cfg_ct),
            .shadow_clr(shadow_clr),
            .latch     (latch),
            .run       (run),
            .wrap      (wrap),
            .clear     (err_clr),
            .cnt       (cnt_q),
            .tx_out    (tx_out[i]),
            .err_flag  (err_flags[i])
        );
    end

    assign is_active = is_active_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule
